local_pattern_predictor: RTL and testbench
==========================================

# local_pattern_predictor

Second level of the front-end local branch predictor. It sits directly downstream of the local history table and consumes that table's 10-bit history output as an index into a pattern table of saturating counters. It produces a registered taken/not-taken prediction one cycle after a read, and applies resolved-branch updates. After every reset it runs a self-clearing sequence, because the counter array has no reset.

## Interface
- hist_width_p, 10, history/index width; the table holds 2^hist_width_p entries
- ctr_width_p, 2, saturating counter width
- init_ctr_p, 1, value loaded into every counter during init (weakly not-taken)

- clk_i  input  1  clock; all state changes on the rising edge
- reset_i  input  1  reset, asynchronous, active-low
- init_done_o  output  1  high when the table is cleared and requests are accepted
- r_v_i  input  1  prediction read request
- r_hist_i  input  hist_width_p  local history from the history table (read index)
- predict_v_o  output  1  prediction valid, one cycle after an accepted read
- predict_taken_o  output  1  MSB of the read counter
- predict_ctr_o  output  ctr_width_p  full counter value read
- w_v_i  input  1  update request for a resolved branch
- w_hist_i  input  hist_width_p  history that was used when this branch was predicted
- w_taken_i  input  1  resolved direction

## Operation
- Two states: INIT and READY. Reset assertion forces INIT asynchronously, with init_idx=0.
- INIT, one action per clock edge:
  - write init_ctr_p to entry init_idx, then increment init_idx
  - on the edge that writes entry 2^hist_width_p-1, go to READY
- init_done_o is registered and equals (state==READY).
- While in INIT:
  - r_v_i is ignored and predict_v_o stays 0
  - w_v_i is dropped; the array is touched only by the init sequence
- READY, update (w_v_i=1): read-modify-write of entry w_hist_i in a single edge.
  - taken: ctr+1, saturating at 2^ctr_width_p-1
  - not taken: ctr-1, saturating at 0
  - No wrap-around under any input sequence.
- READY, read (r_v_i=1): on the edge, the block registers the following, and predict_v_o is 1 for that cycle.
  - predict_ctr_o = entry r_hist_i
  - predict_taken_o = predict_ctr_o[ctr_width_p-1]
- READY with r_v_i=0: predict_v_o goes to 0; predict_ctr_o and predict_taken_o hold their last values.
- Simultaneous read and update on the same edge:
  - same index: the prediction returns the post-update value (write-first bypass)
  - different indices: both take effect independently
- Reset mid-operation (in either state): state returns to INIT and the full clear sequence restarts. Previously trained contents are discarded.

## Timing
- Reset values: init_done_o=0, predict_v_o=0, predict_taken_o=0, predict_ctr_o=0, state=INIT, init_idx=0.
- Init duration: 2^hist_width_p edges after reset deassertion. With defaults, init_done_o first reads 1 after the 1024th rising edge.
- Read latency: 1 cycle. A request on edge N gives a valid prediction during cycle N..N+1.
- Update latency: an update on edge N is visible to a read on edge N (bypass) and on every later edge.
- No backpressure. Every request while init_done_o=1 is accepted in the same cycle.
- Array storage: read is combinational from the index, write is synchronous. Synthesis may infer distributed RAM or flops.

## Test plan
- Reset, then idle: predict_v_o=0 and init_done_o=0 for edges 1..1023; init_done_o=1 after edge 1024; read of index 0 and index 1023 returns ctr=1, taken=0.
- Saturation at index 0x2A5:
  - 3× w_taken_i=1, then read: ctr=3, taken=1
  - 2 more taken updates, then read: still 3
  - 5× not taken, then read: ctr=0, taken=0
- Bypass at index 0x100 (ctr=1):
  - same edge: w_v_i=1, w_taken_i=1, r_v_i=1, both indices 0x100 → predict_ctr_o=2, taken=1
  - same edge with the read index at 0x101 instead → the read returns 1
- Requests during INIT: drive r_v_i=1 and w_v_i=1, w_taken_i=1 on index 5 for all init cycles → predict_v_o never 1; after init, read of index 5 returns 1.
- Reset mid-operation:
  - train index 7 to ctr=3, then pulse reset_i low for 2 ns between edges → outputs go to 0 immediately
  - after re-init (1024 edges), index 7 reads 1
- Read-valid timing: r_v_i high for 1 cycle, then low → predict_v_o high for exactly 1 cycle; predict_ctr_o holds its value afterwards.

Source files
------------

// File: rtl/local_pattern_predictor.sv
// local_pattern_predictor: history-indexed saturating-counter pattern table with self-clearing init
module local_pattern_predictor #(
    parameter int hist_width_p = 10,
    parameter int ctr_width_p  = 2,
    parameter int init_ctr_p   = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    output logic                    init_done_o,
    input  logic                    r_v_i,
    input  logic [hist_width_p-1:0] r_hist_i,
    output logic                    predict_v_o,
    output logic                    predict_taken_o,
    output logic [ctr_width_p-1:0]  predict_ctr_o,
    input  logic                    w_v_i,
    input  logic [hist_width_p-1:0] w_hist_i,
    input  logic                    w_taken_i
);
    localparam int entries_lp = 2 ** hist_width_p;
    localparam logic [ctr_width_p-1:0] ctr_max_lp = {ctr_width_p{1'b1}};

    typedef enum logic {INIT, READY} state_e;

    state_e                  state_q, state_d;
    logic [hist_width_p-1:0] init_idx_q;
    logic [ctr_width_p-1:0]  mem [entries_lp];
    logic [ctr_width_p-1:0]  w_cur, w_next, r_ctr, wr_data;
    logic [hist_width_p-1:0] wr_addr;
    logic                    wr_en, rd_en, upd_en;

    // state register; reset always restarts the clear sequence
    always_ff @(posedge clk_i or negedge reset_i)
        if (!reset_i) state_q <= INIT;
        else          state_q <= state_d;

    // leave INIT on the edge that writes the last entry
    always_comb
        state_d = (state_q == INIT && init_idx_q == {hist_width_p{1'b1}}) ? READY : state_q;

    // control outputs: requests only count once the table is cleared
    always_comb begin
        init_done_o = state_q == READY;
        upd_en      = init_done_o && w_v_i;
        rd_en       = init_done_o && r_v_i;
        wr_en       = (state_q == INIT) || upd_en;
        wr_addr     = init_done_o ? w_hist_i : init_idx_q;
        wr_data     = init_done_o ? w_next : ctr_width_p'(init_ctr_p);
    end

    // clear-sequence pointer
    always_ff @(posedge clk_i or negedge reset_i)
        if (!reset_i) init_idx_q <= '0;
        else          init_idx_q <= (state_q == INIT) ? init_idx_q + hist_width_p'(1) : init_idx_q;

    // saturating update value and write-first read bypass
    always_comb begin
        w_cur  = mem[w_hist_i];
        w_next = w_taken_i ? ((w_cur == ctr_max_lp) ? w_cur : w_cur + 1'b1)
                           : ((w_cur == '0) ? w_cur : w_cur - 1'b1);
        r_ctr  = (upd_en && w_hist_i == r_hist_i) ? w_next : mem[r_hist_i];
    end

    // counter array, no reset: cleared by the init sequence
    always_ff @(posedge clk_i)
        if (wr_en) mem[wr_addr] <= wr_data;

    // registered prediction; counter holds when no read is accepted
    always_ff @(posedge clk_i or negedge reset_i)
        if (!reset_i) begin
            predict_v_o   <= 1'b0;
            predict_ctr_o <= '0;
        end else begin
            predict_v_o <= rd_en;
            if (rd_en) predict_ctr_o <= r_ctr;
        end

    assign predict_taken_o = predict_ctr_o[ctr_width_p-1];
endmodule

// File: tb/tb_local_pattern_predictor.sv
// tb_local_pattern_predictor: directed scenarios for the local pattern predictor
module tb_local_pattern_predictor;
    logic       clk_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       init_done_o;
    logic       r_v_i = 1'b0;
    logic [9:0] r_hist_i = '0;
    logic       predict_v_o;
    logic       predict_taken_o;
    logic [1:0] predict_ctr_o;
    logic       w_v_i = 1'b0;
    logic [9:0] w_hist_i = '0;
    logic       w_taken_i = 1'b0;

    int vectors = 0;
    int errors  = 0;

    local_pattern_predictor dut (
        .clk_i(clk_i), .reset_i(reset_i), .init_done_o(init_done_o),
        .r_v_i(r_v_i), .r_hist_i(r_hist_i),
        .predict_v_o(predict_v_o), .predict_taken_o(predict_taken_o), .predict_ctr_o(predict_ctr_o),
        .w_v_i(w_v_i), .w_hist_i(w_hist_i), .w_taken_i(w_taken_i)
    );

    always #5 clk_i = ~clk_i;

    // one clock edge with the given request inputs, sampled 1 ns after the edge
    task automatic step(input logic rv, input logic [9:0] rh, input logic wv, input logic [9:0] wh, input logic wt);
        r_v_i = rv; r_hist_i = rh; w_v_i = wv; w_hist_i = wh; w_taken_i = wt;
        @(posedge clk_i);
        #1;
        r_v_i = 1'b0; w_v_i = 1'b0;
    endtask

    task automatic expect_read(input string name, input logic [9:0] idx, input logic [1:0] ctr);
        step(1'b1, idx, 1'b0, '0, 1'b0);
        vectors++;
        if (predict_v_o !== 1'b1 || predict_ctr_o !== ctr || predict_taken_o !== ctr[1]) begin
            errors++;
            $display("FAIL %s idx=%h: v=%b ctr=%0d taken=%b, want v=1 ctr=%0d taken=%b",
                     name, idx, predict_v_o, predict_ctr_o, predict_taken_o, ctr, ctr[1]);
        end
    endtask

    task automatic run_init(input logic with_requests);
        for (int i = 1; i <= 1024; i++) begin
            if (with_requests) step(1'b1, 10'd5, 1'b1, 10'd5, 1'b1);
            else               step(1'b0, '0, 1'b0, '0, 1'b0);
            vectors++;
            if (predict_v_o !== 1'b0 || init_done_o !== (i == 1024)) begin
                errors++;
                $display("FAIL init edge %0d: v=%b done=%b, want v=0 done=%b", i, predict_v_o, init_done_o, i == 1024);
            end
        end
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if (init_done_o !== 1'b0 || predict_v_o !== 1'b0 || predict_ctr_o !== 2'd0 || predict_taken_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: done=%b v=%b ctr=%0d taken=%b, want all 0", init_done_o, predict_v_o, predict_ctr_o, predict_taken_o);
        end
        #9 reset_i = 1'b1;
    endtask

    task automatic test_init_idle();
        run_init(1'b0);
        expect_read("init idx0", 10'd0, 2'd1);
        expect_read("init idx1023", 10'd1023, 2'd1);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 10'h2A5, 1'b1);
        expect_read("sat up", 10'h2A5, 2'd3);
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 10'h2A5, 1'b1);
        expect_read("sat hold max", 10'h2A5, 2'd3);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 10'h2A5, 1'b0);
        expect_read("sat floor", 10'h2A5, 2'd0);
    endtask

    task automatic test_bypass();
        step(1'b1, 10'h100, 1'b1, 10'h100, 1'b1);
        vectors++;
        if (predict_v_o !== 1'b1 || predict_ctr_o !== 2'd2 || predict_taken_o !== 1'b1) begin
            errors++;
            $display("FAIL bypass same: v=%b ctr=%0d taken=%b, want v=1 ctr=2 taken=1", predict_v_o, predict_ctr_o, predict_taken_o);
        end
        step(1'b1, 10'h101, 1'b1, 10'h100, 1'b1);
        vectors++;
        if (predict_v_o !== 1'b1 || predict_ctr_o !== 2'd1 || predict_taken_o !== 1'b0) begin
            errors++;
            $display("FAIL bypass diff: v=%b ctr=%0d taken=%b, want v=1 ctr=1 taken=0", predict_v_o, predict_ctr_o, predict_taken_o);
        end
        expect_read("bypass written", 10'h100, 2'd3);
    endtask

    task automatic test_read_valid();
        expect_read("rv pulse", 10'h100, 2'd3);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 10'h2A5, 1'b0, '0, 1'b0);
            vectors++;
            if (predict_v_o !== 1'b0 || predict_ctr_o !== 2'd3 || predict_taken_o !== 1'b1) begin
                errors++;
                $display("FAIL rv hold %0d: v=%b ctr=%0d taken=%b, want v=0 ctr=3 taken=1", i, predict_v_o, predict_ctr_o, predict_taken_o);
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 10'd7, 1'b1);
        expect_read("train idx7", 10'd7, 2'd3);
        #2 reset_i = 1'b0;
        #1;
        vectors++;
        if (init_done_o !== 1'b0 || predict_v_o !== 1'b0 || predict_ctr_o !== 2'd0 || predict_taken_o !== 1'b0) begin
            errors++;
            $display("FAIL mid reset: done=%b v=%b ctr=%0d taken=%b, want all 0", init_done_o, predict_v_o, predict_ctr_o, predict_taken_o);
        end
        #1 reset_i = 1'b1;
        run_init(1'b1);
        expect_read("init ignores writes idx5", 10'd5, 2'd1);
        expect_read("reinit idx7", 10'd7, 2'd1);
    endtask

    initial begin
        test_reset();
        test_init_idle();
        test_saturation();
        test_bypass();
        test_read_valid();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
